// File: rtl/fnorm_seq_if.sv
// Handshake bundle for fnorm_seq: the input word with its valid/ready pair,
// and the output word with its valid/ready pair.
interface fnorm_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [23:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_word
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_word
  );
endinterface

// File: rtl/fnorm_seq.sv
// Sequential single-precision normalizer: shifts the mantissa left one bit per clock.
// Build option FNORM_FLUSH_EN: underflow termination emits signed zero instead of a denormal.
module fnorm_seq (
  input  logic          clk,
  input  logic          rst_n,
  fnorm_seq_if.slave    bus,
  output logic [1:0]    dbg_state
);

  // Handshake: a word moves on a rising edge only when valid and ready are both
  // high; in_ready is high only in IDLE, out_valid only in DONE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        s, s_nxt;
  logic [7:0]  e, e_nxt;
  logic [23:0] m, m_nxt;
  logic [31:0] word, word_nxt;
  logic [31:0] uflow_word;

`ifdef FNORM_FLUSH_EN
  assign uflow_word = {s, 31'b0};
`else
  assign uflow_word = {s, 8'h00, m[22:0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      s     <= 1'b0;
      e     <= 8'h00;
      m     <= 24'h000000;
      word  <= 32'h00000000;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      e     <= e_nxt;
      m     <= m_nxt;
      word  <= word_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    e_nxt     = e;
    m_nxt     = m;
    word_nxt  = word;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          s_nxt     = bus.in_sign;
          e_nxt     = bus.in_exp;
          m_nxt     = bus.in_mant;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // Priority order matters: a special exponent wins over a zero mantissa.
        if (e == 8'hFF) begin
          word_nxt  = {s, e, m[22:0]};
          state_nxt = DONE;
        end else if (m == 24'h000000) begin
          word_nxt  = {s, 31'b0};
          state_nxt = DONE;
        end else if (m[23]) begin
          word_nxt  = {s, e, m[22:0]};
          state_nxt = DONE;
        end else if (e <= 8'd1) begin
          word_nxt  = uflow_word;
          state_nxt = DONE;
        end else begin
          m_nxt = {m[22:0], 1'b0};
          e_nxt = e - 8'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_word  = word;
  assign dbg_state     = state;

endmodule
